// File: rtl/hazard_sequencer_if.sv
// Pipeline hazard control bus.
// Groups the operand/hazard inputs, the SRAM handshake and the pipeline
// control outputs of hazard_sequencer.
//   master : pipeline side, drives hazard/handshake inputs, observes controls
//   slave  : hazard_sequencer, consumes inputs, drives controls and status
interface hazard_sequencer_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       id_src1;
  logic [4:0]       id_src2;
  logic             id_two_src;
  logic [4:0]       ex_dst;
  logic             ex_wb_en;
  logic             ex_mem_read;
  logic [4:0]       mem_dst;
  logic             mem_wb_en;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             stat_clr;

  logic             freeze_pc;
  logic             freeze_if_id;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic             freeze_id_ex;
  logic             freeze_ex_mem;
  logic             bubble_mem_wb;
  logic             mem_error;
  logic [CNT_W-1:0] stall_cnt;
  logic [1:0]       state;

  modport master (
    output id_src1, id_src2, id_two_src, ex_dst, ex_wb_en, ex_mem_read,
           mem_dst, mem_wb_en, branch_taken, mem_req, mem_ready, stat_clr,
    input  freeze_pc, freeze_if_id, flush_if_id, flush_id_ex, freeze_id_ex,
           freeze_ex_mem, bubble_mem_wb, mem_error, stall_cnt, state
  );

  modport slave (
    input  id_src1, id_src2, id_two_src, ex_dst, ex_wb_en, ex_mem_read,
           mem_dst, mem_wb_en, branch_taken, mem_req, mem_ready, stat_clr,
    output freeze_pc, freeze_if_id, flush_if_id, flush_id_ex, freeze_id_ex,
           freeze_ex_mem, bubble_mem_wb, mem_error, stall_cnt, state
  );
endinterface

// File: rtl/hazard_sequencer.sv
// Pipeline control unit for the 5-stage core.
// Produces freeze/flush controls for PC, IF/ID, ID/EX, EX/MEM and a bubble
// into MEM/WB. Resolves load-use/RAW hazards, taken branches from EX and
// multi-cycle SRAM accesses (wait FSM with timeout into a sticky ERROR).
// Ports:
//   clk : rising-edge clock
//   rst : synchronous reset, active-low
//   bus : hazard_sequencer_if.slave (hazard inputs, SRAM handshake,
//         stat_clr; control outputs, mem_error, stall_cnt, state)
module hazard_sequencer #(
  parameter int unsigned FORWARD_EN  = 1,
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic           clk,
  input  logic           rst,
  hazard_sequencer_if.slave bus
);

  localparam int unsigned WCW = $clog2(MEM_TIMEOUT) + 1;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  state_t           st;
  logic [WCW-1:0]   wait_cnt;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;

  logic match_ex;
  logic match_mem;
  logic hz;
  logic ms;
  logic frz_pc, frz_if_id, fl_if_id, fl_id_ex, frz_id_ex, frz_ex_mem, bub;

  function automatic logic src_match(
    input logic [4:0] dst,
    input logic [4:0] s1,
    input logic [4:0] s2,
    input logic       two
  );
    return (dst != 5'd0) && ((dst == s1) || (two && (dst == s2)));
  endfunction

  always_comb begin
    match_ex  = src_match(bus.ex_dst,  bus.id_src1, bus.id_src2, bus.id_two_src);
    match_mem = src_match(bus.mem_dst, bus.id_src1, bus.id_src2, bus.id_two_src);
    if (FORWARD_EN != 0)
      hz = bus.ex_mem_read & bus.ex_wb_en & match_ex;
    else
      hz = (bus.ex_wb_en & match_ex) | (bus.mem_wb_en & match_mem);
  end

  always_comb begin
    ms = 1'b0;
    case (st)
      RUN:      ms = bus.mem_req & ~bus.mem_ready;
      MEM_WAIT: ms = ~bus.mem_ready;
      default:  ms = 1'b1;
    endcase
  end

  // Memory stall outranks the branch flush: EX is frozen and re-presents
  // the branch once the access completes.
  always_comb begin
    frz_pc     = 1'b0;
    frz_if_id  = 1'b0;
    fl_if_id   = 1'b0;
    fl_id_ex   = 1'b0;
    frz_id_ex  = 1'b0;
    frz_ex_mem = 1'b0;
    bub        = 1'b0;
    if (ms) begin
      frz_pc     = 1'b1;
      frz_if_id  = 1'b1;
      frz_id_ex  = 1'b1;
      frz_ex_mem = 1'b1;
      bub        = 1'b1;
    end else if (bus.branch_taken) begin
      fl_if_id = 1'b1;
      fl_id_ex = 1'b1;
    end else if (hz) begin
      frz_pc    = 1'b1;
      frz_if_id = 1'b1;
      fl_id_ex  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      st       <= RUN;
      wait_cnt <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      case (st)
        RUN: begin
          if (bus.mem_req && !bus.mem_ready) begin
            st       <= MEM_WAIT;
            wait_cnt <= WCW'(1);
          end
        end
        MEM_WAIT: begin
          if (bus.mem_ready) begin
            st       <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WCW'(MEM_TIMEOUT - 1)) begin
            st    <= ERROR;
            err_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
        end
        default: begin
          st    <= ERROR;
          err_q <= 1'b1;
        end
      endcase

      if (bus.stat_clr)
        cnt_q <= '0;
      else if (frz_pc && (cnt_q != '1))
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.freeze_pc     = frz_pc;
  assign bus.freeze_if_id  = frz_if_id;
  assign bus.flush_if_id   = fl_if_id;
  assign bus.flush_id_ex   = fl_id_ex;
  assign bus.freeze_id_ex  = frz_id_ex;
  assign bus.freeze_ex_mem = frz_ex_mem;
  assign bus.bubble_mem_wb = bub;
  assign bus.mem_error     = err_q;
  assign bus.stall_cnt     = cnt_q;
  assign bus.state         = st;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Scoreboard bench for hazard_sequencer: two instances
// (u1: forwarding, MEM_TIMEOUT=4, CNT_W=16; u0: no forwarding, CNT_W=3).
module tb_hazard_sequencer;

  logic clk = 1'b0;
  logic rst1, rst0;
  always #5 clk = ~clk;

  hazard_sequencer_if #(.CNT_W(16)) i1 ();
  hazard_sequencer_if #(.CNT_W(3))  i0 ();

  hazard_sequencer #(.FORWARD_EN(1), .MEM_TIMEOUT(4), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst1), .bus(i1)
  );
  hazard_sequencer #(.FORWARD_EN(0), .MEM_TIMEOUT(64), .CNT_W(3)) u0 (
    .clk(clk), .rst(rst0), .bus(i0)
  );

  // ctrl = {freeze_pc, freeze_if_id, flush_if_id, flush_id_ex,
  //         freeze_id_ex, freeze_ex_mem, bubble_mem_wb}
  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_HZ   = 7'b1101000;
  localparam logic [6:0] C_BR   = 7'b0011000;
  localparam logic [6:0] C_MS   = 7'b1100111;

  typedef struct {
    int         sel;
    string      name;
    logic [6:0] ctrl;
    logic [1:0] st;
    logic       err;
    int         cnt;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic clr1();
    i1.id_src1 = '0; i1.id_src2 = '0; i1.id_two_src = 1'b0;
    i1.ex_dst = '0; i1.ex_wb_en = 1'b0; i1.ex_mem_read = 1'b0;
    i1.mem_dst = '0; i1.mem_wb_en = 1'b0; i1.branch_taken = 1'b0;
    i1.mem_req = 1'b0; i1.mem_ready = 1'b0; i1.stat_clr = 1'b0;
  endtask

  task automatic clr0();
    i0.id_src1 = '0; i0.id_src2 = '0; i0.id_two_src = 1'b0;
    i0.ex_dst = '0; i0.ex_wb_en = 1'b0; i0.ex_mem_read = 1'b0;
    i0.mem_dst = '0; i0.mem_wb_en = 1'b0; i0.branch_taken = 1'b0;
    i0.mem_req = 1'b0; i0.mem_ready = 1'b0; i0.stat_clr = 1'b0;
  endtask

  // Inputs for this cycle are already applied; queue what the monitor must
  // see during the cycle, then advance to just after the next edge.
  task automatic expect_cyc(input int sel, input string name, input logic [6:0] ctrl,
                            input logic [1:0] st, input logic err, input int cnt);
    exp_t e;
    e.sel = sel; e.name = name; e.ctrl = ctrl; e.st = st; e.err = err; e.cnt = cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are steady mid-cycle, compare on the falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [6:0] a_ctrl;
      logic [1:0] a_st;
      logic       a_err;
      int         a_cnt;
      e = sb.pop_front();
      if (e.sel == 1) begin
        a_ctrl = {i1.freeze_pc, i1.freeze_if_id, i1.flush_if_id, i1.flush_id_ex,
                  i1.freeze_id_ex, i1.freeze_ex_mem, i1.bubble_mem_wb};
        a_st = i1.state; a_err = i1.mem_error; a_cnt = int'(i1.stall_cnt);
      end else begin
        a_ctrl = {i0.freeze_pc, i0.freeze_if_id, i0.flush_if_id, i0.flush_id_ex,
                  i0.freeze_id_ex, i0.freeze_ex_mem, i0.bubble_mem_wb};
        a_st = i0.state; a_err = i0.mem_error; a_cnt = int'(i0.stall_cnt);
      end
      n_cmp++;
      if (a_ctrl !== e.ctrl || a_st !== e.st || a_err !== e.err || a_cnt != e.cnt) begin
        n_bad++;
        $display("FAIL %s: got ctrl=%b state=%0d err=%b cnt=%0d, want ctrl=%b state=%0d err=%b cnt=%0d",
                 e.name, a_ctrl, a_st, a_err, a_cnt, e.ctrl, e.st, e.err, e.cnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    clr1(); clr0();
    rst1 = 1'b0; rst0 = 1'b0;
    @(posedge clk); #1;
    rst1 = 1'b1; rst0 = 1'b1;

    // ---- u1: forwarding present ----
    expect_cyc(1, "reset_idle", C_NONE, 2'd0, 1'b0, 0);
    i1.ex_mem_read = 1'b1; i1.ex_wb_en = 1'b1; i1.ex_dst = 5'd5; i1.id_src1 = 5'd5;
    expect_cyc(1, "load_use", C_HZ, 2'd0, 1'b0, 0);
    clr1();
    expect_cyc(1, "after_load_use", C_NONE, 2'd0, 1'b0, 1);
    i1.ex_mem_read = 1'b1; i1.ex_wb_en = 1'b1; i1.ex_dst = 5'd0; i1.id_src1 = 5'd0;
    expect_cyc(1, "reg0_no_hz", C_NONE, 2'd0, 1'b0, 1);
    i1.ex_dst = 5'd5; i1.id_src1 = 5'd5; i1.branch_taken = 1'b1;
    expect_cyc(1, "branch_over_hz", C_BR, 2'd0, 1'b0, 1);
    i1.branch_taken = 1'b0; i1.id_src1 = 5'd3; i1.id_src2 = 5'd5; i1.id_two_src = 1'b1;
    expect_cyc(1, "load_use_src2", C_HZ, 2'd0, 1'b0, 1);
    i1.id_two_src = 1'b0;
    expect_cyc(1, "src2_unused", C_NONE, 2'd0, 1'b0, 2);
    clr1();
    i1.mem_req = 1'b1;
    expect_cyc(1, "mem_wait_c1", C_MS, 2'd0, 1'b0, 2);
    i1.mem_req = 1'b0;
    expect_cyc(1, "mem_wait_req_drop", C_MS, 2'd1, 1'b0, 3);
    i1.branch_taken = 1'b1;
    expect_cyc(1, "mem_wait_branch_mask", C_MS, 2'd1, 1'b0, 4);
    i1.branch_taken = 1'b0; i1.mem_ready = 1'b1;
    expect_cyc(1, "mem_ready_release", C_NONE, 2'd1, 1'b0, 5);
    clr1();
    expect_cyc(1, "back_to_run", C_NONE, 2'd0, 1'b0, 5);
    i1.mem_req = 1'b1; i1.mem_ready = 1'b1;
    expect_cyc(1, "zero_wait", C_NONE, 2'd0, 1'b0, 5);
    clr1();
    i1.ex_mem_read = 1'b1; i1.ex_wb_en = 1'b1; i1.ex_dst = 5'd9; i1.id_src1 = 5'd9;
    i1.stat_clr = 1'b1;
    expect_cyc(1, "clr_over_inc", C_HZ, 2'd0, 1'b0, 5);
    clr1();
    expect_cyc(1, "after_clr", C_NONE, 2'd0, 1'b0, 0);
    i1.mem_req = 1'b1;
    expect_cyc(1, "tmo_c1", C_MS, 2'd0, 1'b0, 0);
    expect_cyc(1, "tmo_c2", C_MS, 2'd1, 1'b0, 1);
    expect_cyc(1, "tmo_c3", C_MS, 2'd1, 1'b0, 2);
    expect_cyc(1, "tmo_c4", C_MS, 2'd1, 1'b0, 3);
    i1.mem_ready = 1'b1;
    expect_cyc(1, "error_entered", C_MS, 2'd2, 1'b1, 4);
    i1.mem_req = 1'b0; i1.mem_ready = 1'b0;
    expect_cyc(1, "error_sticky", C_MS, 2'd2, 1'b1, 5);
    rst1 = 1'b0;
    @(posedge clk); #1;
    rst1 = 1'b1;
    expect_cyc(1, "error_reset", C_NONE, 2'd0, 1'b0, 0);

    // ---- u0: no forwarding, 3-bit stall counter ----
    i0.mem_wb_en = 1'b1; i0.mem_dst = 5'd7; i0.id_two_src = 1'b1;
    i0.id_src2 = 5'd7; i0.id_src1 = 5'd1;
    expect_cyc(0, "raw_mem_src2", C_HZ, 2'd0, 1'b0, 0);
    i0.id_two_src = 1'b0;
    expect_cyc(0, "raw_src2_unused", C_NONE, 2'd0, 1'b0, 1);
    clr0();
    i0.ex_wb_en = 1'b1; i0.ex_dst = 5'd4; i0.id_src1 = 5'd4;
    for (int i = 0; i < 8; i++)
      expect_cyc(0, "raw_ex_sat", C_HZ, 2'd0, 1'b0, (1 + i > 7) ? 7 : 1 + i);
    clr0();
    expect_cyc(0, "sat_hold", C_NONE, 2'd0, 1'b0, 7);
    i0.mem_wb_en = 1'b1; i0.mem_dst = 5'd0; i0.id_src1 = 5'd0;
    expect_cyc(0, "raw_reg0", C_NONE, 2'd0, 1'b0, 7);
    clr0();

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
Pipeline control unit for the 5-stage core. It produces the freeze and flush controls for the PC, the IF/ID register, the ID/EX register and the EX/MEM register. It resolves three cases:
- load-use and RAW hazards, against the operands currently in ID/EX and EX/MEM;
- taken branches resolved in EX;
- multi-cycle SRAM accesses from MEM, using a wait FSM with timeout.

Parameters:
FORWARD_EN, 1, 1: forwarding unit present, so only load-use stalls; 0: stall on any RAW match in EX or MEM.
MEM_TIMEOUT, 64, max MEM_WAIT cycles before ERROR (>=2).
CNT_W, 16, width of the stall statistics counter.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-low
id_src1  in  5  ID source register 1
id_src2  in  5  ID source register 2
id_two_src  in  1  instruction in ID reads id_src2
ex_dst  in  5  destination held in ID/EX
ex_wb_en  in  1  write-back enable held in ID/EX
ex_mem_read  in  1  mem read held in ID/EX
mem_dst  in  5  destination held in EX/MEM
mem_wb_en  in  1  write-back enable held in EX/MEM
branch_taken  in  1  EX resolved a taken branch
mem_req  in  1  MEM stage issues an SRAM read or write
mem_ready  in  1  SRAM completes the access this cycle
stat_clr  in  1  clear stall_cnt
freeze_pc  out  1  hold PC
freeze_if_id  out  1  hold IF/ID
flush_if_id  out  1  zero IF/ID
flush_id_ex  out  1  zero ID/EX (bubble)
freeze_id_ex  out  1  hold ID/EX
freeze_ex_mem  out  1  hold EX/MEM
bubble_mem_wb  out  1  write zeros into MEM/WB
mem_error  out  1  sticky SRAM timeout flag
stall_cnt  out  CNT_W  cycles with freeze_pc=1, saturating
state  out  2  FSM state: 0 RUN, 1 MEM_WAIT, 2 ERROR

Behaviour:
Reset (rst=0 at a clk edge):
- state=RUN, wait_cnt=0, mem_error=0, stall_cnt=0.
- All control outputs are combinational, so with no hazard inputs they are 0.

Hazard term hz (combinational):
- A source match requires src!=0 and either src==id_src1, or (id_two_src and src==id_src2).
- FORWARD_EN=1: hz = ex_mem_read & ex_wb_en & match(ex_dst).
- FORWARD_EN=0: hz = (ex_wb_en & match(ex_dst)) | (mem_wb_en & match(mem_dst)).

Memory stall term ms (combinational):
- In RUN: ms = mem_req & ~mem_ready.
- In MEM_WAIT: ms = ~mem_ready.
- In ERROR: ms = 1.

Control outputs, evaluated in priority order:
1. ms=1: freeze_pc, freeze_if_id, freeze_id_ex and freeze_ex_mem are 1; bubble_mem_wb=1; both flushes are 0. branch_taken and hz are ignored, because EX is frozen and re-presents the branch after the stall.
2. Otherwise branch_taken=1: flush_if_id=1 and flush_id_ex=1; all freezes are 0. The flush also suppresses any hz bubble.
3. Otherwise hz=1: freeze_pc=1, freeze_if_id=1, flush_id_ex=1.
4. Otherwise all control outputs are 0.

FSM transitions:
- RUN -> MEM_WAIT when mem_req & ~mem_ready; wait_cnt<=1.
- RUN stays in RUN when mem_req & mem_ready in the same cycle. This is a zero-stall access.
- MEM_WAIT -> RUN on mem_ready. Freezes drop in that same cycle and the pipeline advances on the next edge; wait_cnt<=0.
- MEM_WAIT otherwise: wait_cnt<=wait_cnt+1. When wait_cnt==MEM_TIMEOUT-1 and ~mem_ready, go to ERROR and set mem_error<=1.
- ERROR: absorbing; only rst leaves it. mem_error stays 1 and the pipeline stays frozen.

Statistics counter:
- stall_cnt increments by 1 on each edge where freeze_pc=1, saturating at all-ones.
- stat_clr=1 loads 0 and has priority over the increment.
- In ERROR, stall_cnt keeps counting until saturation.

Boundaries:
- mem_req is sampled only in RUN. A mem_req drop while in MEM_WAIT is ignored; the FSM waits for mem_ready.
- Register 0 never creates a hazard.
- Reset asserted during MEM_WAIT or ERROR returns to RUN in the next cycle, with no residual freeze.

Test Plan:
- Load-use stall: FORWARD_EN=1, ex_mem_read=1, ex_wb_en=1, ex_dst=5, id_src1=5 for one cycle -> freeze_pc=1, freeze_if_id=1, flush_id_ex=1 that cycle; stall_cnt goes 0->1.
- Register-0 and branch priority: ex_dst=0, id_src1=0 -> no stall. Then a load-use hazard with branch_taken=1 -> flush_if_id=1, flush_id_ex=1, freeze_pc=0.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 -> state 0,1,1,1,0. All freezes are 1 for exactly 3 cycles and 0 in the mem_ready cycle; stall_cnt=3.
- Zero-wait and branch masking: mem_req=1, mem_ready=1 same cycle -> state stays RUN, no freeze. A branch_taken during MEM_WAIT -> flush_if_id=0.
- Timeout: MEM_TIMEOUT=4, mem_req=1, mem_ready held 0 -> ERROR and mem_error=1 on the 4th edge; freezes stay 1. rst=0 for one edge -> state=0, mem_error=0, stall_cnt=0.
- FORWARD_EN=0 RAW: mem_wb_en=1, mem_dst=7, id_two_src=1, id_src2=7 -> stall. With id_two_src=0 -> no stall. stall_cnt saturation checked with CNT_W=3 (stops at 7).
